// File: rtl/input_debounce2_pkg.sv
// Shared encodings and defaults for the two-channel input debouncer.
package input_debounce2_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  // 10 ms at 100 MHz
  localparam int unsigned DEFAULT_STABLE_COUNT = 1000000;

endpackage : input_debounce2_pkg

// File: rtl/debounce_channel.sv
// One debounced channel: 2-flop synchroniser, hold counter and accept FSM.
// clean/rise/fall are registered; rise/fall pulse in the cycle clean changes.
module debounce_channel
  import input_debounce2_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  // A count of 1 would make WAIT_* states meaningless
  if (STABLE_COUNT < 2) begin : g_bad_stable_count
    $error("debounce_channel: STABLE_COUNT must be >= 2");
  end

  logic             s1;
  logic             s2;
  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_d;
  logic             rise_d;
  logic             fall_d;

  // Two-stage synchroniser for the asynchronous raw level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Next-state, counter and output decode; counter clears on any reversal
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    clean_d = clean;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s2) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        clean_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      clean   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean   <= clean_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

endmodule : debounce_channel

// File: rtl/input_debounce2.sv
// Two independent debounce channels feeding a 2-input gate: clean[1]=A, clean[0]=B.
module input_debounce2
  import input_debounce2_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] raw_in,
  output logic [1:0] clean,
  output logic [1:0] rise,
  output logic [1:0] fall
);

  // Channel A (bit 1)
  debounce_channel #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_chan_a (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_in[1]),
    .clean   (clean[1]),
    .rise    (rise[1]),
    .fall    (fall[1])
  );

  // Channel B (bit 0)
  debounce_channel #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_chan_b (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw_in[0]),
    .clean   (clean[0]),
    .rise    (rise[0]),
    .fall    (fall[0])
  );

endmodule : input_debounce2

// File: tb/tb_input_debounce2.sv
// Scoreboard bench for input_debounce2 with STABLE_COUNT=4.
// Expected pulse events carry the posedge count at which they must appear:
// a raw change made after posedge k yields its pulse at posedge k+6.
module tb_input_debounce2;

  typedef struct {
    int unsigned pe;
    logic [1:0]  clean;
    logic [1:0]  rise;
    logic [1:0]  fall;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] raw_in = 2'b11;
  logic [1:0] clean;
  logic [1:0] rise;
  logic [1:0] fall;

  int unsigned pe = 0;
  int          total = 0;
  int          bad = 0;
  ev_t         exp_q[$];

  input_debounce2 #(
    .STABLE_COUNT (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_in  (raw_in),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pe <= pe + 1;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s pe=%0d got=%b want=%b", name, pe, act, exp);
    end
  endtask

  task automatic push(input int unsigned at, input logic [1:0] c,
                      input logic [1:0] r, input logic [1:0] f);
    ev_t e;
    e.pe = at; e.clean = c; e.rise = r; e.fall = f;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse the DUT presents must match the next expected event
  always @(negedge clk) begin
    if ((rise | fall) != 2'b00) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse pe=%0d rise=%b fall=%b clean=%b", pe, rise, fall, clean);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.pe != pe || e.rise !== rise || e.fall !== fall || e.clean !== clean) begin
          bad++;
          $display("FAIL pulse_event got pe=%0d r=%b f=%b c=%b want pe=%0d r=%b f=%b c=%b",
                   pe, rise, fall, clean, e.pe, e.rise, e.fall, e.clean);
        end
      end
    end
  end

  initial begin
    int unsigned k;
    logic [1:0]  all;

    // Reset held with both inputs high
    cycles(3);
    chk("reset_clean", clean, 2'b00);
    all = rise | fall;
    chk("reset_pulses", all, 2'b00);

    // Release with raw high: normal accept path, rise on both
    k = pe;
    reset_n = 1'b1;
    push(k + 6, 2'b11, 2'b11, 2'b00);
    cycles(5);
    chk("t1_clean_before", clean, 2'b00);
    cycles(1);
    chk("t1_clean_after", clean, 2'b11);
    cycles(4);

    // Both fall together
    k = pe;
    raw_in = 2'b00;
    push(k + 6, 2'b00, 2'b00, 2'b11);
    cycles(5);
    chk("t3_clean_before", clean, 2'b11);
    cycles(1);
    chk("t3_clean_after", clean, 2'b00);
    cycles(4);

    // 3-cycle glitch on A is rejected
    raw_in = 2'b10;
    cycles(3);
    raw_in = 2'b00;
    cycles(10);
    chk("t2_glitch_clean", clean, 2'b00);

    // 4-cycle pulse on A is accepted, then the release is accepted too
    k = pe;
    raw_in = 2'b10;
    push(k + 6, 2'b10, 2'b10, 2'b00);
    push(k + 10, 2'b00, 2'b00, 2'b10);
    cycles(4);
    raw_in = 2'b00;
    cycles(2);
    chk("t2_accept_clean", clean, 2'b10);
    cycles(8);
    chk("t2_release_clean", clean, 2'b00);

    // Bounce on B for 20 cycles, then hold high
    for (int i = 0; i < 20; i++) begin
      raw_in = (i % 2 == 0) ? 2'b01 : 2'b00;
      cycles(1);
    end
    chk("t4_bounce_clean", clean, 2'b00);
    k = pe;
    raw_in = 2'b01;
    push(k + 6, 2'b01, 2'b01, 2'b00);
    cycles(6);
    chk("t4_accept_clean", clean, 2'b01);
    cycles(2);
    k = pe;
    raw_in = 2'b00;
    push(k + 6, 2'b00, 2'b00, 2'b01);
    cycles(10);

    // Staggered rises: A at edge 0, B at edge 2
    k = pe;
    raw_in = 2'b10;
    push(k + 6, 2'b10, 2'b10, 2'b00);
    push(k + 8, 2'b11, 2'b01, 2'b00);
    cycles(2);
    raw_in = 2'b11;
    cycles(4);
    chk("t5_a_only", clean, 2'b10);
    cycles(2);
    chk("t5_both", clean, 2'b11);
    cycles(3);
    k = pe;
    raw_in = 2'b00;
    push(k + 6, 2'b00, 2'b00, 2'b11);
    cycles(10);

    // Async reset while both channels sit in WAIT_HI
    raw_in = 2'b11;
    cycles(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_wait_clean", clean, 2'b00);
    all = rise | fall;
    chk("t6_wait_pulses", all, 2'b00);
    cycles(2);
    k = pe;
    reset_n = 1'b1;
    push(k + 6, 2'b11, 2'b11, 2'b00);
    cycles(5);
    chk("t6_reaccept_before", clean, 2'b00);
    cycles(1);
    // Reset mid-cycle while clean=1 and rise is high
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_hi_clean", clean, 2'b00);
    chk("t6_hi_rise", rise, 2'b00);
    raw_in = 2'b00;
    cycles(2);
    reset_n = 1'b1;
    cycles(10);
    chk("t6_final_clean", clean, 2'b00);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got=%0d pending want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_input_debounce2

// File: doc/input_debounce2.md
Name: input_debounce2

Overview:
- Two-channel input conditioner that drives the A and B inputs of the 2-input gate exercises.
- Takes raw, asynchronous, bouncy pushbutton/switch levels and synchronises them to `clk`.
- Debounces each channel independently and presents clean levels plus one-cycle edge pulses.
- Sits directly upstream of the gate: `clean[1]` drives A, `clean[0]` drives B.

Parameters:
- STABLE_COUNT, 1000000, consecutive synchronised cycles a new level must hold before it is accepted (10 ms at 100 MHz). Legal range is >= 2; elaboration fails otherwise.
- CNT_W, $clog2(STABLE_COUNT+1), counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- raw_in  input  2  unsynchronised button/switch levels; bit1 = channel A, bit0 = channel B.
- clean  output  2  debounced, registered levels.
- rise  output  2  one-cycle pulse when clean[i] goes 0->1.
- fall  output  2  one-cycle pulse when clean[i] goes 1->0.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- While reset_n=0:
  - all flops clear: sync stages, counters, state = STABLE_LO.
  - clean=0, rise=0, fall=0, effective immediately without waiting for a clock.
- Reset release is not treated specially. If raw_in is high at release, the channel goes through the normal accept path and emits a rise pulse.
- Synchroniser: per channel, two flops s1 <= raw_in[i], s2 <= s1. The FSM sees only s2.
- Per-channel FSM, with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO:
  - STABLE_LO: if s2=1, go to WAIT_HI with cnt=1; otherwise stay, cnt=0.
  - WAIT_HI, s2=0: return to STABLE_LO, cnt=0. The glitch is rejected and no pulse is emitted.
  - WAIT_HI, s2=1 and cnt<STABLE_COUNT-1: cnt++.
  - WAIT_HI, s2=1 and cnt=STABLE_COUNT-1: go to STABLE_HI, clean[i]<=1, rise[i]<=1 for exactly one cycle, cnt=0.
  - STABLE_HI / WAIT_LO: mirror of the above with polarities swapped. Acceptance sets clean[i]<=0 and fall[i]<=1 for one cycle.
- Latency:
  - raw_in[i] changes before edge 0 and then holds.
  - s2 changes after edge 1.
  - clean[i] and the pulse are visible after edge 1+STABLE_COUNT. With STABLE_COUNT=4, that is after edge 5.
- Pulse timing: rise/fall are asserted in the same cycle that clean changes and deassert on the next edge. They are never asserted at the same time on one channel.
- Counter: never exceeds STABLE_COUNT-1 and cannot wrap. It is cleared on every state change and on every level reversal.
- Channels are fully independent. Simultaneous transitions on both bits produce independent, possibly coincident, pulses.
- Reset mid-operation (any state, any cnt): outputs drop to 0 asynchronously and all counts are lost.
- Bounce of any length restarts the count at each reversal. Exactly one pulse is emitted per accepted level change.
- All outputs are registered, with no combinational path from raw_in.

Decomposition:
- Shared package holds:
  - FSM state encoding: STABLE_LO=2'd0, WAIT_HI=2'd1, STABLE_HI=2'd2, WAIT_LO=2'd3.
  - DEFAULT_STABLE_COUNT = 1000000.
- Sub-module debounce_channel (ports: clk, reset_n, raw, clean, rise, fall; parameter STABLE_COUNT) contains the synchroniser, counter and FSM for one bit.
- input_debounce2 instantiates debounce_channel twice. The top level has no other logic.

Test Plan (STABLE_COUNT=4, edges counted from reset release):
- Reset with raw_in=2'b11, then release -> clean=2'b00 before edge 5, clean=2'b11 after edge 5, rise=2'b11 for one cycle only, fall=0 throughout.
- From clean=0, drive raw_in[1] high for 3 cycles then low -> clean, rise and fall remain 0. Repeat with 4 cycles -> clean[1]=1 and rise[1] for one cycle.
- With clean=2'b11, set raw_in=2'b00 and hold -> clean=2'b00 exactly 5 edges later, fall=2'b11 for one cycle, no rise.
- Toggle raw_in[0] every cycle for 20 cycles, then hold 1 -> exactly one rise[0] pulse, 5 edges after the final change. Channel 1 is unaffected.
- Raise raw_in[1] at edge 0 and raw_in[0] at edge 2 -> rise[1] after edge 5, rise[0] after edge 7, each one cycle wide.
- Assert reset_n=0 asynchronously (mid-clock) while a channel is in WAIT_HI, or with clean=1 -> outputs go to 0 before the next edge. After release, a steady high input is re-accepted after a full 5-edge latency.
